// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT controller types, default sizes and the L-bit rotate helper
package fft_pkg;
  localparam int FFT_L    = 9;
  localparam int FFT_PIPE = 3;
  localparam int FFT_N    = 2 ** FFT_L;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, DONE} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s, input int w);
    return ((x << s) | (x >> (w - s))) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/fft_ctrl_reindex_bits.sv
// reindex_bits: W-bit bit reversal used to scramble sample load addresses
module reindex_bits #(
  parameter int W = 9
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] out_bits
);
  for (genvar g = 0; g < W; g++) begin : g_rev
    assign out_bits[g] = in_bits[W-1-g];
  end
endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: radix-2 FFT sequencer (load, per-stage butterfly reads, delayed writes, status); FFT_CTRL_BITREV_EN bit-reverses load addresses
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int L    = FFT_L,
  parameter int PIPE = FFT_PIPE
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         load_valid,
  output logic         load_ready,
  output logic [L-1:0] load_adr,
  output logic         load_we,
  output logic [L-1:0] rd_adr_a,
  output logic [L-1:0] rd_adr_b,
  output logic         rd_en,
  output logic [L-2:0] tw_adr,
  output logic [L-1:0] wr_adr_a,
  output logic [L-1:0] wr_adr_b,
  output logic         wr_en,
  output logic         bank,
  output logic         busy,
  output logic         done,
  output logic         res_bank
);
  localparam int SW = $clog2(L + 1);
  localparam int DW = $clog2(PIPE + 1);
  localparam int PW = PIPE * L;

  state_t                   state_q, state_d;
  logic [L-1:0]             k_q, k_d, k_map;
  logic [L-2:0]             i_q, i_d, tw_mask;
  logic [SW-1:0]            s_q, s_d;
  logic [DW-1:0]            cnt_q, cnt_d;
  logic                     bank_q, bank_d, res_bank_q, res_bank_d;
  logic [PIPE-1:0]          pen_q, pen_d;
  logic [PIPE-1:0][L-1:0]   pa_q, pa_d, pb_q, pb_d;

`ifdef FFT_CTRL_BITREV_EN
  reindex_bits #(.W(L)) u_rev (.in_bits(k_q), .out_bits(k_map));
`else
  assign k_map = k_q;
`endif

  // state, counters and the read-to-write delay line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      i_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      bank_q     <= 1'b0;
      res_bank_q <= 1'b0;
      pen_q      <= '0;
      pa_q       <= '0;
      pb_q       <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      i_q        <= i_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      res_bank_q <= res_bank_d;
      pen_q      <= pen_d;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
    end
  end

  // next-state sequencing plus address generation, all outputs gated by state
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    i_d        = i_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    res_bank_d = res_bank_q;
    load_ready = state_q == LOAD;
    load_we    = load_ready && load_valid;
    load_adr   = load_ready ? k_map : '0;
    rd_en      = state_q == CALC;
    tw_mask    = {(L-1){1'b1}} << (L - 1 - int'(s_q));
    rd_adr_a   = rd_en ? L'(rotl(32'({i_q, 1'b0}), int'(s_q), L)) : '0;
    rd_adr_b   = rd_en ? L'(rotl(32'({i_q, 1'b1}), int'(s_q), L)) : '0;
    tw_adr     = rd_en ? (i_q & tw_mask) : '0;
    pen_d      = PIPE'({pen_q, rd_en});
    pa_d       = PW'({pa_q, rd_adr_a});
    pb_d       = PW'({pb_q, rd_adr_b});
    wr_en      = pen_q[PIPE-1];
    wr_adr_a   = pa_q[PIPE-1];
    wr_adr_b   = pb_q[PIPE-1];
    bank       = bank_q;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    res_bank   = res_bank_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        k_d     = '0;
      end
      LOAD: if (load_valid) begin
        k_d = k_q + 1'b1;
        if (&k_q) begin
          state_d = CALC;
          k_d     = '0;
          i_d     = '0;
          s_d     = '0;
          bank_d  = 1'b0;
        end
      end
      CALC: begin
        i_d = i_q + 1'b1;
        if (&i_q) begin
          state_d = DRAIN;
          i_d     = '0;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DW'(PIPE - 1)) begin
          if (s_q == SW'(L - 1)) begin
            state_d    = DONE;
            res_bank_d = 1'(L % 2);
          end else begin
            state_d = CALC;
            s_d     = s_q + 1'b1;
            bank_d  = ~bank_q;
            i_d     = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: scoreboard bench for fft_ctrl (L=3, PIPE=3) with a behavioural address model
module tb_fft_ctrl;
  localparam int L = 3, PIPE = 3, N = 1 << L, LAT = L * (N / 2 + PIPE) + 1;
`ifdef FFT_CTRL_BITREV_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic clk = 0, reset_n = 0, start = 0, load_valid = 0;
  logic load_ready, load_we, rd_en, wr_en, bank, busy, done, res_bank;
  logic [L-1:0] load_adr, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [L-2:0] tw_adr;
  logic [24:0] outs_w;

  fft_ctrl #(.L(L), .PIPE(PIPE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .load_valid(load_valid),
    .load_ready(load_ready), .load_adr(load_adr), .load_we(load_we),
    .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .rd_en(rd_en), .tw_adr(tw_adr),
    .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b), .wr_en(wr_en), .bank(bank),
    .busy(busy), .done(done), .res_bank(res_bank)
  );

  assign outs_w = {load_ready, load_adr, load_we, rd_adr_a, rd_adr_b, rd_en, tw_adr,
                   wr_adr_a, wr_adr_b, wr_en, bank, busy, done, res_bank};

  always #5 clk = ~clk;

  typedef struct {int a; int b; int tw; int s;} rd_e_t;
  typedef struct {int a; int b; int s; int t;} wr_e_t;

  int    exp_load[$];
  rd_e_t exp_rd[$];
  wr_e_t wq[$];
  int    exp_done[$];
  int    total = 0, bad = 0, cyc = 0, calc_start = -1, s1_reads = 0;
  int    wcnt[L];
  logic  prev_done = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // rotation as multiplication by 2^s modulo 2^L-1 (all-ones is a fixed point)
  function automatic int rot(input int v, input int s);
    return (v == N - 1) ? v : (v << s) % (N - 1);
  endfunction

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < L; b++) r |= ((k >> b) & 1) << (L - 1 - b);
    return r;
  endfunction

  task automatic push_exp();
    for (int k = 0; k < N; k++) exp_load.push_back(BR ? rev(k) : k);
    for (int s = 0; s < L; s++)
      for (int i = 0; i < N / 2; i++)
        exp_rd.push_back(rd_e_t'{rot(2 * i, s), rot(2 * i + 1, s),
                                 (i >> (L - 1 - s)) << (L - 1 - s), s});
    exp_done.push_back(LAT);
  endtask

  task automatic flush();
    exp_load.delete();
    exp_rd.delete();
    wq.delete();
    exp_done.delete();
    calc_start = -1;
    s1_reads = 0;
    for (int s = 0; s < L; s++) wcnt[s] = 0;
  endtask

  always @(posedge clk) cyc++;

  // monitor: compares every observed load/read/write/done against the queued model
  always @(negedge clk) begin
    rd_e_t e;
    wr_e_t w;
    if (!reset_n) chk("reset_outs", outs_w, 0);
    else begin
      if (load_ready) chk("load_we", load_we, load_valid);
      if (load_we) begin
        chk("load_pending", exp_load.size() != 0, 1);
        if (exp_load.size() != 0) chk("load_adr", load_adr, exp_load.pop_front());
      end
      if (rd_en) begin
        chk("rd_pending", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          e = exp_rd.pop_front();
          if (calc_start < 0) calc_start = cyc;
          chk("rd_adr_a", rd_adr_a, e.a);
          chk("rd_adr_b", rd_adr_b, e.b);
          chk("tw_adr", tw_adr, e.tw);
          chk("bank", bank, e.s % 2);
          if (e.s > 0) chk("stage_order", wcnt[e.s - 1], N / 2);
          if (e.s == 1) s1_reads++;
          wq.push_back(wr_e_t'{e.a, e.b, e.s, cyc});
        end
      end
      if (wr_en) begin
        chk("wr_pending", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("wr_adr_a", wr_adr_a, w.a);
          chk("wr_adr_b", wr_adr_b, w.b);
          chk("wr_delay", cyc - w.t, PIPE);
          wcnt[w.s]++;
        end
      end
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("done_pending", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) chk("done_latency", cyc - calc_start + 1, exp_done.pop_front());
        chk("res_bank", res_bank, L % 2);
        chk("busy_done", busy, 1);
        calc_start = -1;
        s1_reads = 0;
        for (int s = 0; s < L; s++) wcnt[s] = 0;
      end
    end
    prev_done = done;
  end

  task automatic kick(input bit hold);
    start = 1;
    @(posedge clk);
    #1 start = hold;
    chk("start_taken", load_ready, 1);
  endtask

  task automatic do_load(input bit gaps);
    int n = 0, g = 0;
    bit acc;
    while (n < N && g < 200) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = load_ready && load_valid;
      @(posedge clk);
      #1;
      if (acc) n++;
      g++;
    end
    load_valid = 0;
    chk("load_count", n, N);
  endtask

  task automatic wait_done();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 300);
    chk("done_seen", done, 1);
  endtask

  task automatic full_run(input bit gaps);
    push_exp();
    kick(1'b0);
    do_load(gaps);
    wait_done();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    for (int s = 0; s < L; s++) wcnt[s] = 0;
    repeat (3) @(posedge clk);
    #1 chk("init_outs", outs_w, 0);
    reset_n = 1;
    full_run(1'b0);
    full_run(1'b1);
    full_run(1'b1);
    // abort during stage 1 and recover
    push_exp();
    kick(1'b0);
    do_load(1'b1);
    g = 0;
    while (s1_reads < 2 && g < 100) begin
      @(posedge clk);
      #1 g++;
    end
    chk("reach_stage1", s1_reads >= 2, 1);
    reset_n = 0;
    #1 chk("async_reset_outs", outs_w, 0);
    flush();
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    full_run(1'b1);
    // start held across two runs
    push_exp();
    push_exp();
    kick(1'b1);
    do_load(1'b1);
    wait_done();
    @(posedge clk);
    #1 chk("idle_gap_busy", busy, 0);
    chk("idle_gap_ready", load_ready, 0);
    @(posedge clk);
    #1 chk("relaunch", load_ready, 1);
    do_load(1'b1);
    wait_done();
    start = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 chk("no_third_run", busy, 0);
    chk("left_load", exp_load.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_wr", wq.size(), 0);
    chk("left_done", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter L SHALL default to 9 and set the FFT size to N = 2^L points.
REQ-002 Parameter PIPE SHALL default to 3 and give the cycles from a read issue to its butterfly result, memory read included.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock, rising-edge.
REQ-004 Port reset_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: request a new FFT; sampled only in IDLE.
REQ-006 Ports load_valid (input, 1 bit) and load_ready (output, 1 bit) SHALL form the sample-load handshake.
REQ-007 Ports load_adr (output, L bits) and load_we (output, 1 bit) SHALL give the bank-0 write address and write enable for the incoming sample.
REQ-008 Ports rd_adr_a and rd_adr_b (outputs, L bits each) and rd_en (output, 1 bit) SHALL drive the butterfly operand reads.
REQ-009 Port tw_adr (output, L-1 bits) SHALL give the twiddle ROM address for the operand pair being issued.
REQ-010 Ports wr_adr_a and wr_adr_b (outputs, L bits each) and wr_en (output, 1 bit) SHALL drive the butterfly result writes.
REQ-011 Port bank (output, 1 bit) SHALL name the read bank; writes SHALL go to ~bank.
REQ-012 Ports busy (output, 1 bit), done (output, 1 bit, one-cycle pulse) and res_bank (output, 1 bit, the bank that holds the final spectrum) SHALL report status.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, CALC, DRAIN and DONE.
REQ-014 IDLE SHALL go to LOAD on start=1; start SHALL be ignored in every other state.
REQ-015 In LOAD: load_ready=1; each cycle with load_valid=1 SHALL assert load_we the same cycle, increment load counter k, and drive load_adr = k.
REQ-016 After sample N-1 is accepted, LOAD SHALL go to CALC with stage s=0, butterfly i=0 and bank=0.
REQ-017 In CALC, one butterfly per cycle SHALL issue with rd_en=1: rd_adr_a = rotl_L(2i, s), rd_adr_b = rotl_L(2i+1, s), tw_adr = i with its low (L-1-s) bits cleared.
REQ-018 When i = N/2-1 issues, CALC SHALL go to DRAIN, and DRAIN SHALL last exactly PIPE cycles with rd_en=0.
REQ-019 wr_en, wr_adr_a and wr_adr_b SHALL equal rd_en, rd_adr_a and rd_adr_b delayed by exactly PIPE cycles through a shift register, so the last write of stage s lands in the final DRAIN cycle.
REQ-020 On DRAIN exit: if s < L-1, then s++, bank toggles, i=0 and the FSM returns to CALC; otherwise the FSM goes to DONE.
REQ-021 No read of stage s+1 SHALL issue in the same cycle as, or before, the last write of stage s.
REQ-022 DONE SHALL last one cycle with done=1, latch res_bank = L[0], then return to IDLE.
REQ-023 busy SHALL be 1 in LOAD, CALC, DRAIN and DONE, and 0 in IDLE.
REQ-024 The i and k counters SHALL wrap to 0 only through the state transitions above; an overflow past N-1 SHALL never be visible on any address port.

Reset
REQ-025 reset_n=0 SHALL, asynchronously and at any state, force IDLE and clear s, i, k, bank, res_bank and the delay line.
REQ-026 While reset_n=0, every output SHALL be 0, and any butterfly in flight SHALL be discarded with no write.
REQ-027 After reset_n rises, the first start SHALL be honoured on the first rising clk edge.

Configuration
REQ-028 With FFT_CTRL_BITREV_EN defined, load_adr SHALL be the L-bit bit-reversal of k, giving natural-order output.
REQ-029 Without FFT_CTRL_BITREV_EN, load_adr SHALL equal k, and input reordering is the upstream block's duty.

Structure
REQ-030 A shared package fft_pkg SHALL hold the FSM state enum and the constants FFT_L and FFT_PIPE, plus the default N derived from FFT_L.
REQ-031 Bit reversal SHALL reuse the shared sub-module reindex_bits; rotl_L SHALL be a package function.

Verification
REQ-032 With L=3, PIPE=3, pulse start, then give 8 back-to-back load_valid -> load_adr = 0..7 without BITREV, and 0,4,2,6,1,5,3,7 with it.
REQ-033 With L=3, check stage 0 i=0 -> rd_adr_a/b = 0/1, tw_adr = 0; stage 1 i=1 -> 4/6, tw 0; stage 1 i=3 -> 5/7, tw 2; stage 2 i=1 -> 1/5, tw 1.
REQ-034 With L=3, PIPE=3, load 8 samples -> done pulses exactly 22 cycles after the first CALC cycle (3*(4+3)+1), with res_bank=1.
REQ-035 Every wr_en pulse SHALL match the rd_en pulse PIPE cycles earlier in both addresses, with no write overlapping a next-stage read.
REQ-036 Assert reset_n=0 mid-CALC at stage 1 -> all outputs 0 at once, no further wr_en, and a new start runs a full, correct FFT.
REQ-037 Hold start=1 throughout a run -> exactly one FFT per IDLE entry, and the start held through DONE launches the next run only from IDLE.
